// File: rtl/bpsk_demod_stream_if.sv
// rtl/bpsk_demod_stream_if.sv - symbol-in / codeword-out stream bundle for the BPSK demapper
interface bpsk_demod_stream_if #(
    parameter int MAX_N = 15,
    parameter int CNT_W = 4
);
    localparam int LW = $clog2(MAX_N + 1);

    logic [1:0]       sym_in;
    logic             sym_valid;
    logic             sym_ready;
    logic [LW-1:0]    cw_len;
    logic             sync;
    logic [MAX_N-1:0] data_out;
    logic [MAX_N-1:0] erase_mask;
    logic [CNT_W-1:0] erase_cnt;
    logic             data_valid;
    logic             data_ready;

    // Symbol source and codeword sink side
    modport master (
        output sym_in, sym_valid, cw_len, sync, data_ready,
        input  sym_ready, data_out, erase_mask, erase_cnt, data_valid
    );

    // Demapper side
    modport slave (
        input  sym_in, sym_valid, cw_len, sync, data_ready,
        output sym_ready, data_out, erase_mask, erase_cnt, data_valid
    );
endinterface

// File: rtl/bpsk_demod_stream.sv
// rtl/bpsk_demod_stream.sv - streaming BPSK hard-decision demapper assembling variable-length codewords
module bpsk_demod_stream #(
    parameter int MAX_N = 15,
    parameter int CNT_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bpsk_demod_stream_if.slave   bus
);
    localparam int LW = $clog2(MAX_N + 1);

    typedef enum logic {COLLECT, HOLD} state_t;

    state_t           state_q, state_d;
    logic [LW-1:0]    idx_q, idx_d;
    logic [LW-1:0]    len_q, len_d;
    logic [MAX_N-1:0] shift_q, shift_d;
    logic [MAX_N-1:0] mask_q, mask_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [MAX_N-1:0] data_q, data_d;
    logic [MAX_N-1:0] emask_q, emask_d;
    logic [CNT_W-1:0] ecnt_q, ecnt_d;
    logic             valid_q, valid_d;

    logic             sym_ready;
    logic             sym_xfer;
    logic             word_xfer;
    logic             erasure;
    logic             bit_val;
    logic [LW-1:0]    len_in;
    logic [LW-1:0]    cur_len;
    logic             last_sym;
    logic [MAX_N-1:0] len_mask;

    // Handshake qualifiers, demap decision and length bookkeeping for the current symbol
    always_comb begin
        sym_ready = (state_q == COLLECT) ? 1'b1 : bus.data_ready;
        sym_xfer  = bus.sym_valid & sym_ready;
        word_xfer = valid_q & bus.data_ready;
        erasure   = (bus.sym_in == 2'b00) || (bus.sym_in == 2'b11);
        // Anything that is not 01 decides to 1, erasures included
        bit_val   = (bus.sym_in != 2'b01);
        // Lengths 0, 1 and anything beyond MAX_N fall back to the full word
        if ((bus.cw_len < LW'(2)) || (bus.cw_len > LW'(MAX_N))) begin
            len_in = LW'(MAX_N);
        end else begin
            len_in = bus.cw_len;
        end
        // The first symbol of a word uses the length being latched with it
        cur_len  = (idx_q == '0) ? len_in : len_q;
        last_sym = (idx_q == (cur_len - 1'b1));
        len_mask = '0;
        for (int i = 0; i < MAX_N; i++) begin
            len_mask[i] = (LW'(i) < cur_len);
        end
    end

    // Next-state logic: collect symbols, publish a finished word, hold it until accepted
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        shift_d = shift_q;
        mask_d  = mask_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        emask_d = emask_q;
        ecnt_d  = ecnt_q;
        valid_d = valid_q;

        case (state_q)
            COLLECT: ;
            HOLD: begin
                if (word_xfer) begin
                    valid_d = 1'b0;
                    state_d = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase

        // In HOLD a symbol is only accepted alongside the word transfer, so it
        // always lands at index 0 of the next word and can never finish it
        if (sym_xfer && !bus.sync) begin
            shift_d[idx_q] = bit_val;
            mask_d[idx_q]  = erasure;
            if (erasure && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_d = cnt_q + 1'b1;
            end
            if (idx_q == '0) begin
                len_d = len_in;
            end
            if (last_sym) begin
                data_d  = shift_d & len_mask;
                emask_d = mask_d & len_mask;
                ecnt_d  = cnt_d;
                valid_d = 1'b1;
                idx_d   = '0;
                shift_d = '0;
                mask_d  = '0;
                cnt_d   = '0;
                state_d = HOLD;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end

        // Sync throws away only the partial word; a held word is untouched
        if (bus.sync) begin
            idx_d   = '0;
            shift_d = '0;
            mask_d  = '0;
            cnt_d   = '0;
        end
    end

    // State register with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= COLLECT;
            idx_q   <= '0;
            len_q   <= LW'(MAX_N);
            shift_q <= '0;
            mask_q  <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            emask_q <= '0;
            ecnt_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            shift_q <= shift_d;
            mask_q  <= mask_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            emask_q <= emask_d;
            ecnt_q  <= ecnt_d;
            valid_q <= valid_d;
        end
    end

    assign bus.sym_ready  = sym_ready;
    assign bus.data_out   = data_q;
    assign bus.erase_mask = emask_q;
    assign bus.erase_cnt  = ecnt_q;
    assign bus.data_valid = valid_q;
endmodule

// File: tb/tb_bpsk_demod_stream.sv
// tb/tb_bpsk_demod_stream.sv - self-checking bench for bpsk_demod_stream
module tb_bpsk_demod_stream;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bpsk_demod_stream_if #(.MAX_N(15), .CNT_W(4)) b ();
    bpsk_demod_stream_if #(.MAX_N(15), .CNT_W(2)) b2 ();

    bpsk_demod_stream #(.MAX_N(15), .CNT_W(4)) dut  (.clk(clk), .rst_n(rst_n), .bus(b));
    bpsk_demod_stream #(.MAX_N(15), .CNT_W(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));

    typedef struct {
        logic [3:0]  len;
        logic [3:0]  len2;
        int          nsym;
        logic [31:0] syms;
        logic [14:0] d;
        logic [14:0] m;
        logic [3:0]  c;
    } vec_t;

    typedef struct {
        logic [14:0] d;
        logic [14:0] m;
        logic [3:0]  c;
    } exp_t;

    vec_t vecs[6];
    exp_t sbq[$];
    int n_checks = 0;
    int n_fail = 0;
    int words_seen = 0;
    int words_pushed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [14:0] d, input logic [14:0] m, input logic [3:0] c);
        exp_t e;
        e.d = d; e.m = m; e.c = c;
        sbq.push_back(e);
        words_pushed++;
    endtask

    // Scoreboard: every accepted word is compared against the oldest expectation
    always @(negedge clk) begin
        if (rst_n && b.data_valid && b.data_ready) begin
            words_seen++;
            check("sb_nonempty", 32'(sbq.size() != 0), 32'd1);
            if (sbq.size() != 0) begin
                exp_t e;
                e = sbq.pop_front();
                check("word_data", 32'(b.data_out), 32'(e.d));
                check("word_mask", 32'(b.erase_mask), 32'(e.m));
                check("word_cnt", 32'(b.erase_cnt), 32'(e.c));
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the symbol has been taken
    task automatic send_sym(input logic [1:0] s, input logic [3:0] l);
        int t;
        t = 0;
        b.sym_in = s;
        b.cw_len = l;
        b.sym_valid = 1'b1;
        @(negedge clk);
        while (!b.sym_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!b.sym_ready) check("sym_accept", 32'(b.sym_ready), 32'd1);
        @(posedge clk);
        #1;
        b.sym_valid = 1'b0;
    endtask

    task automatic send_word(input vec_t v);
        for (int k = 0; k < v.nsym; k++) begin
            send_sym(v.syms[2*k +: 2], (k == 0) ? v.len : v.len2);
        end
        check("valid_after_last", 32'(b.data_valid), 32'd1);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (b.data_valid && t < 20) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (b.data_valid) check("drain", 32'(b.data_valid), 32'd0);
    endtask

    initial begin
        int len;
        logic [1:0] s;
        exp_t e;
        int t;

        b.sym_in = 2'b00; b.sym_valid = 1'b0; b.cw_len = '0; b.sync = 1'b0; b.data_ready = 1'b1;
        b2.sym_in = 2'b00; b2.sym_valid = 1'b0; b2.cw_len = '0; b2.sync = 1'b0; b2.data_ready = 1'b1;

        //          len    len2   n   symbols packed LSB first       data      mask      cnt
        vecs[0] = '{4'd7,  4'd7,  7,  32'h0000_2669, 15'h0056, 15'h0000, 4'd0};
        vecs[1] = '{4'd15, 4'd15, 15, 32'h1575_5515, 15'h0408, 15'h0408, 4'd2};
        vecs[2] = '{4'd0,  4'd0,  15, 32'h2AAA_AAAA, 15'h7FFF, 15'h0000, 4'd0};
        vecs[3] = '{4'd12, 4'd7,  12, 32'h0066_6666, 15'h0555, 15'h0000, 4'd0};
        vecs[4] = '{4'd1,  4'd1,  15, 32'h3FFF_FFFF, 15'h7FFF, 15'h7FFF, 4'd15};
        vecs[5] = '{4'd2,  4'd2,  2,  32'h0000_0001, 15'h0002, 15'h0002, 4'd1};

        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(b.data_valid), 32'd0);
        check("rst_data", 32'(b.data_out), 32'd0);
        check("rst_mask", 32'(b.erase_mask), 32'd0);
        check("rst_cnt", 32'(b.erase_cnt), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_sym_ready", 32'(b.sym_ready), 32'd1);

        // Table-driven words, streamed back to back
        for (int i = 0; i < 6; i++) begin
            push_exp(vecs[i].d, vecs[i].m, vecs[i].c);
            send_word(vecs[i]);
        end

        // Random words with a reference demapper; cw_len is scrambled mid-word
        for (int r = 0; r < 6; r++) begin
            case ($urandom_range(0, 2))
                0: len = 7;
                1: len = 12;
                default: len = 15;
            endcase
            e.d = '0; e.m = '0; e.c = '0;
            for (int k = 0; k < len; k++) begin
                s = 2'($urandom_range(0, 3));
                e.d[k] = (s != 2'b01);
                e.m[k] = (s == 2'b00) || (s == 2'b11);
                if (e.m[k] && e.c != 4'd15) e.c = e.c + 4'd1;
            end
            push_exp(e.d, e.m, e.c);
            // regenerate the same symbols from the model so stimulus and expectation agree
            for (int k = 0; k < len; k++) begin
                if (e.m[k]) s = (k % 2 == 0) ? 2'b00 : 2'b11;
                else        s = e.d[k] ? 2'b10 : 2'b01;
                send_sym(s, (k == 0) ? 4'(len) : 4'($urandom_range(0, 15)));
            end
            check("rand_valid", 32'(b.data_valid), 32'd1);
        end

        // Backpressure: word held, then retired together with the next word's first symbol
        drain();
        b.data_ready = 1'b0;
        push_exp(15'h0056, 15'h0, 4'd0);
        send_word(vecs[0]);
        b.sym_in = 2'b10; b.sym_valid = 1'b1; b.cw_len = 4'd7;
        repeat (5) begin
            @(negedge clk);
            check("bp_valid", 32'(b.data_valid), 32'd1);
            check("bp_data", 32'(b.data_out), 32'h56);
            check("bp_sym_ready", 32'(b.sym_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        b.data_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", 32'(b.sym_ready), 32'd1);
        @(posedge clk);
        #1;
        b.sym_valid = 1'b0;
        check("bp_retired", 32'(b.data_valid), 32'd0);
        push_exp(15'h0001, 15'h0, 4'd0);
        for (int k = 0; k < 6; k++) send_sym(2'b01, 4'd7);
        check("bp_next_valid", 32'(b.data_valid), 32'd1);

        // Sync discards a partial word and the symbol presented with it
        drain();
        for (int k = 0; k < 5; k++) send_sym(2'b00, 4'd12);
        b.sync = 1'b1; b.sym_in = 2'b10; b.sym_valid = 1'b1;
        @(posedge clk);
        #1;
        b.sync = 1'b0; b.sym_valid = 1'b0;
        push_exp(15'h0, 15'h0, 4'd0);
        for (int k = 0; k < 12; k++) send_sym(2'b01, 4'd12);
        check("sync_valid", 32'(b.data_valid), 32'd1);

        // Sync while a word is held leaves it intact
        drain();
        b.data_ready = 1'b0;
        push_exp(vecs[5].d, vecs[5].m, vecs[5].c);
        send_word(vecs[5]);
        b.sync = 1'b1;
        @(posedge clk);
        #1;
        b.sync = 1'b0;
        @(negedge clk);
        check("hold_sync_valid", 32'(b.data_valid), 32'd1);
        check("hold_sync_data", 32'(b.data_out), 32'h2);
        check("hold_sync_mask", 32'(b.erase_mask), 32'h2);
        check("hold_sync_cnt", 32'(b.erase_cnt), 32'd1);
        @(posedge clk);
        #1;
        b.data_ready = 1'b1;
        drain();

        // Narrow counter saturates on an all-erasure word
        b2.cw_len = 4'd7; b2.sym_in = 2'b00; b2.sym_valid = 1'b1;
        t = 0;
        repeat (7) begin
            @(negedge clk);
            if (b2.sym_ready) t++;
            @(posedge clk);
            #1;
        end
        b2.sym_valid = 1'b0;
        check("sat_accepted", 32'(t), 32'd7);
        check("sat_valid", 32'(b2.data_valid), 32'd1);
        check("sat_data", 32'(b2.data_out), 32'h7F);
        check("sat_mask", 32'(b2.erase_mask), 32'h7F);
        check("sat_cnt", 32'(b2.erase_cnt), 32'd3);

        // Asynchronous reset while a word is held
        b.data_ready = 1'b0;
        send_word(vecs[0]);
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(b.data_valid), 32'd0);
        check("arst_data", 32'(b.data_out), 32'd0);
        check("arst_mask", 32'(b.erase_mask), 32'd0);
        check("arst_cnt", 32'(b.erase_cnt), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        b.data_ready = 1'b1;

        // Asynchronous reset mid-word: the next word starts clean
        for (int k = 0; k < 3; k++) send_sym(2'b10, 4'd7);
        rst_n = 1'b0;
        #1;
        check("arst_mid_valid", 32'(b.data_valid), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        push_exp(15'h0056, 15'h0, 4'd0);
        send_word(vecs[0]);

        t = 0;
        while (sbq.size() != 0 && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("sb_drained", 32'(sbq.size()), 32'd0);
        check("word_count", 32'(words_seen), 32'(words_pushed));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/bpsk_demod_stream.md
Name: bpsk_demod_stream

Overview:
Streaming, handshaked successor to the combinational BPSK hard-decision demapper. It accepts one 2-bit BPSK symbol code per transfer and assembles MAX_N-wide codewords whose length is selectable per word at runtime (7, 12 or 15 for Hamming/BCH decoders). It flags erasures (illegal symbol codes) per bit and per word. It sits between the channel/symbol source and the Hamming or BCH decoder.

Parameters:
MAX_N, 15, maximum codeword length in bits; legal range 2..16
CNT_W, 4, width of the per-word erasure count; saturates at 2^CNT_W-1

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
sym_in  in  2  symbol code: 01 -> bit 0, 10 -> bit 1, 00/11 -> erasure
sym_valid  in  1  sym_in valid
sym_ready  out  1  block can accept a symbol this cycle
cw_len  in  clog2(MAX_N+1)  codeword length; sampled when the first symbol of a word is accepted
sync  in  1  synchronous discard of the partial word; highest priority after reset
data_out  out  MAX_N  assembled codeword; bits at and above the latched length are 0
erase_mask  out  MAX_N  1 where the corresponding bit came from an erasure
erase_cnt  out  CNT_W  number of erasures in the word, saturating
data_valid  out  1  word on data_out/erase_mask/erase_cnt is valid
data_ready  in  1  downstream accepts the word

Behaviour:
- Reset (rst_n=0, async): state=COLLECT; bit index=0; latched length=MAX_N; shift/data_out/erase_mask/erase_cnt=0; data_valid=0; sym_ready=1 after reset release.
- Symbol transfer = sym_valid & sym_ready. Word transfer = data_valid & data_ready.
- Demap: 01->0; 10->1; 00 or 11 -> bit 1 with the erase_mask bit set. This keeps the legacy "not 01 is 1" decision.
- Bit order: the first accepted symbol lands in bit 0 (LSB), and the k-th symbol lands in bit k-1.
- Length latch: when a symbol is accepted at index 0, cw_len is latched. A value of 0, 1, or greater than MAX_N is replaced by MAX_N.
- FSM COLLECT: sym_ready=1. Each transfer writes the bit and mask and increments erase_cnt on an erasure (saturating). When the transfer fills index L-1 (L = latched length):
  - copy the word to the output registers, with unused upper bits forced to 0;
  - set data_valid=1 in the next cycle (1-cycle latency from the last symbol);
  - reset the index to 0 and go to HOLD.
- FSM HOLD: outputs are held stable while data_valid=1 and data_ready=0, and sym_ready=0. sym_ready=data_ready, which allows back-to-back operation.
  - A word transfer with no symbol transfer: data_valid=0 next cycle, go to COLLECT.
  - A simultaneous word transfer and symbol transfer: the symbol becomes index 0 of the next word and cw_len is latched; go to COLLECT.
- With L=1 impossible (clamped), the shortest word is 2 symbols, so HOLD never re-enters directly.
- sync=1: clears the index, partial bits, mask and count, and any symbol presented that cycle is dropped. A word already in HOLD is not affected and still completes its handshake. sync has no effect on the latched length of a word already in HOLD.
- cw_len changes mid-word are ignored until the next index-0 acceptance.
- The erase_cnt output belongs to the word on data_out. The internal counter restarts at 0 for each new word.
- Async reset mid-word or mid-HOLD: all state is lost immediately; data_valid drops asynchronously.

Test Plan:
1. Reset, then cw_len=7 and symbols 01,10,10,01,10,01,10 streamed with valid held high -> data_valid rises 1 cycle after the 7th transfer. Expected: data_out=0x56 (bits 0..6 = 0,1,1,0,1,0,1), erase_mask=0, erase_cnt=0, upper bits 0.
2. cw_len=15, 15 symbols with 00 at index 3 and 11 at index 10, all others 01 -> data_out=0x0408, erase_mask=0x0408, erase_cnt=2.
3. Backpressure: after test 1's word, data_ready=0 for 5 cycles -> outputs stable, sym_ready=0, no symbols consumed. data_ready=1 together with sym_valid=1 -> word retires and the new symbol becomes bit 0 of the next word; no cycle is lost.
4. cw_len=12 latched at the first symbol, then changed to 7 mid-word -> the word completes after 12 symbols. cw_len=0 -> the word completes after 15 symbols.
5. sync after 5 symbols of a 12-bit word, then 12 fresh symbols -> one word only, containing just the fresh symbols. sync during HOLD -> the held word is delivered unchanged.
6. With CNT_W=2, a 7-symbol all-00 word -> erase_cnt=3 (saturated), erase_mask=0x7F, data_out=0x7F. Asserting rst_n=0 mid-word -> data_valid=0 and outputs zero immediately.
